// File: rtl/jump_ctrl_pkg.sv
// Shared types and helpers for the jump request controller.
package jump_ctrl_pkg;

  // Direction codes carried by the pending-press register.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DebCntW = 6;
  localparam int unsigned TmoCntW = 8;

  typedef enum logic [0:0] {
    StIdle     = 1'b0,
    StWaitLand = 1'b1
  } jump_state_e;

  // Saturating increment for the landing-timeout counter.
  function automatic logic [TmoCntW-1:0] sat_inc_tmo(input logic [TmoCntW-1:0] v);
    return (v == '1) ? v : v + TmoCntW'(1);
  endfunction

endpackage

// File: rtl/jump_ctrl_debounce.sv
// Button conditioner: 2-flop synchroniser, ms-tick debounce of both edges,
// and a registered press strobe one cycle after the debounced level rises.
module jump_ctrl_debounce
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic one_ms_tick,
  output logic rise
);

  localparam logic [DebCntW-1:0] DebLimit = DebCntW'(DEBOUNCE_MS);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                level_q, level_d;
  logic                level_dly_q, level_dly_d;
  logic                rise_q, rise_d;
  logic [DebCntW-1:0]  cnt_q, cnt_d;
  logic [DebCntW-1:0]  cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DebCntW'(1);

  // Next-state: sync shift, tick-gated stability counter, edge detect.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    level_dly_d = level_q;
    rise_d      = level_q & ~level_dly_q;
    if (one_ms_tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_inc >= DebLimit) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/jump_ctrl.sv
// Jump request controller: conditions left/right buttons and issues one
// registered jump request per press while the character is idle, then waits
// for landed (or a landing timeout) before accepting the next.
// Optional build macro JUMP_CTRL_BUFFER_EN adds a one-deep, last-wins buffer
// for presses that arrive while a jump is in flight.
module jump_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned TIMEOUT_MS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic module_en,
  input  logic btn_left,
  input  logic btn_right,
  input  logic one_ms_tick,
  input  logic landed,
  output logic jump_left,
  output logic jump_right,
  output logic busy,
  output logic timeout_err
);

  localparam logic [TmoCntW-1:0] TmoLimit = TmoCntW'(TIMEOUT_MS);

  logic rise_left, rise_right;
  logic press_any, press_dir;

  jump_state_e        state_q, state_d;
  logic               jump_left_q, jump_left_d;
  logic               jump_right_q, jump_right_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TmoCntW-1:0] tmo_q, tmo_d;
  logic [TmoCntW-1:0] tmo_inc;
  logic               issue, issue_dir;
`ifdef JUMP_CTRL_BUFFER_EN
  logic               pend_v_q, pend_v_d;
  logic               pend_dir_q, pend_dir_d;
`endif

  jump_ctrl_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_deb_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn_left),
    .one_ms_tick (one_ms_tick),
    .rise        (rise_left)
  );

  jump_ctrl_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_deb_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn_right),
    .one_ms_tick (one_ms_tick),
    .rise        (rise_right)
  );

  // Simultaneous presses resolve to left, matching downstream priority.
  assign press_any = rise_left | rise_right;
  assign press_dir = rise_left ? DIR_LEFT : DIR_RIGHT;
  assign tmo_inc   = sat_inc_tmo(tmo_q);

  // FSM next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    jump_left_d  = 1'b0;
    jump_right_d = 1'b0;
    issue        = 1'b0;
    issue_dir    = DIR_LEFT;
`ifdef JUMP_CTRL_BUFFER_EN
    pend_v_d     = pend_v_q;
    pend_dir_d   = pend_dir_q;
`endif
    if (!module_en) begin
      state_d = StIdle;
      busy_d  = 1'b0;
`ifdef JUMP_CTRL_BUFFER_EN
      pend_v_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef JUMP_CTRL_BUFFER_EN
          if (pend_v_q) begin
            // Buffered press goes first; a fresh press takes its slot.
            issue      = 1'b1;
            issue_dir  = pend_dir_q;
            pend_v_d   = press_any;
            pend_dir_d = press_dir;
          end else if (press_any) begin
            issue     = 1'b1;
            issue_dir = press_dir;
          end
`else
          if (press_any) begin
            issue     = 1'b1;
            issue_dir = press_dir;
          end
`endif
          if (issue) begin
            jump_left_d  = (issue_dir == DIR_LEFT);
            jump_right_d = (issue_dir == DIR_RIGHT);
            busy_d       = 1'b1;
            tmo_d        = '0;
            state_d      = StWaitLand;
          end
        end
        StWaitLand: begin
          // landed wins over a coincident timeout expiry.
          if (landed) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else if (one_ms_tick) begin
            if (tmo_inc >= TmoLimit) begin
              err_d   = 1'b1;
              state_d = StIdle;
              busy_d  = 1'b0;
            end else begin
              tmo_d = tmo_inc;
            end
          end
`ifdef JUMP_CTRL_BUFFER_EN
          if (press_any) begin
            pend_v_d   = 1'b1;
            pend_dir_d = press_dir;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
`ifdef JUMP_CTRL_BUFFER_EN
      pend_v_q     <= 1'b0;
      pend_dir_q   <= DIR_LEFT;
`endif
    end else begin
      state_q      <= state_d;
      jump_left_q  <= jump_left_d;
      jump_right_q <= jump_right_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
`ifdef JUMP_CTRL_BUFFER_EN
      pend_v_q     <= pend_v_d;
      pend_dir_q   <= pend_dir_d;
`endif
    end
  end

  assign jump_left   = jump_left_q;
  assign jump_right  = jump_right_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios plus random button/landed/enable
// traffic, every cycle compared against a timing-level reference model.
module tb_jump_ctrl;

  localparam int DebMs   = 10;
  localparam int TmoMs   = 200;
  localparam int TickDiv = 20;
`ifdef JUMP_CTRL_BUFFER_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic module_en = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic one_ms_tick = 1'b0;
  logic landed = 1'b0;
  logic jump_left, jump_right, busy, timeout_err;

  always #5 clk = ~clk;

  jump_ctrl #(
    .DEBOUNCE_MS (DebMs),
    .TIMEOUT_MS  (TmoMs)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .module_en   (module_en),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .one_ms_tick (one_ms_tick),
    .landed      (landed),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: button samples are kept as a history, the debounced
  // level as an integer run-length count, and a press reaches the request
  // logic two edges after the debounced level rises.
  int edge_n;
  bit hist_l[$];
  bit hist_r[$];
  int m_cnt[2];
  bit m_deb[2];
  int m_rise_edge[2];
  bit m_in_flight, m_err, m_jl, m_jr, m_pend, m_pend_right;
  int m_waited;
  int tick_phase = 0;
  int cnt_jl, cnt_jr;

  function automatic void model_reset();
    edge_n = 0;
    hist_l.delete();
    hist_r.delete();
    for (int b = 0; b < 2; b++) begin
      m_cnt[b] = 0;
      m_deb[b] = 1'b0;
      m_rise_edge[b] = -100;
    end
    m_in_flight = 0; m_err = 0; m_jl = 0; m_jr = 0; m_pend = 0; m_pend_right = 0;
    m_waited = 0;
  endfunction

  function automatic void model_issue(input bit right);
    m_jl = !right;
    m_jr = right;
    m_in_flight = 1'b1;
    m_waited = 0;
  endfunction

  function automatic void model_edge();
    bit in_s[2];
    bit pl, pr, any;
    in_s[0] = (hist_l.size() >= 2) ? hist_l[hist_l.size()-2] : 1'b0;
    in_s[1] = (hist_r.size() >= 2) ? hist_r[hist_r.size()-2] : 1'b0;
    hist_l.push_back(btn_left);
    hist_r.push_back(btn_right);
    if (hist_l.size() > 3) void'(hist_l.pop_front());
    if (hist_r.size() > 3) void'(hist_r.pop_front());

    pl  = (m_rise_edge[0] == edge_n - 2);
    pr  = (m_rise_edge[1] == edge_n - 2) && !pl;
    any = pl || pr;

    m_jl = 1'b0;
    m_jr = 1'b0;
    if (!module_en) begin
      m_in_flight = 1'b0;
      m_pend = 1'b0;
    end else if (!m_in_flight) begin
      if (BufEn && m_pend) begin
        model_issue(m_pend_right);
        m_pend = any;
        m_pend_right = pr;
      end else if (any) begin
        model_issue(pr);
      end
    end else begin
      if (landed) begin
        m_in_flight = 1'b0;
      end else if (one_ms_tick) begin
        m_waited++;
        if (m_waited >= TmoMs) begin
          m_err = 1'b1;
          m_in_flight = 1'b0;
        end
      end
      if (BufEn && any) begin
        m_pend = 1'b1;
        m_pend_right = pr;
      end
    end

    if (one_ms_tick) begin
      for (int b = 0; b < 2; b++) begin
        if (in_s[b] == m_deb[b]) begin
          m_cnt[b] = 0;
        end else begin
          m_cnt[b]++;
          if (m_cnt[b] >= DebMs) begin
            m_deb[b] = in_s[b];
            m_cnt[b] = 0;
            if (m_deb[b]) m_rise_edge[b] = edge_n;
          end
        end
      end
    end
    edge_n++;
  endfunction

  task automatic step();
    one_ms_tick = (tick_phase == TickDiv - 1);
    tick_phase  = (tick_phase + 1) % TickDiv;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    landed = 1'b0;
    check_eq("jump_left", jump_left, m_jl);
    check_eq("jump_right", jump_right, m_jr);
    check_eq("busy", busy, m_in_flight);
    check_eq("timeout_err", timeout_err, m_err);
    check_eq("jump_exclusive", jump_left & jump_right, 0);
    if (jump_left) cnt_jl++;
    if (jump_right) cnt_jr++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic land();
    landed = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    run(3);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_err", timeout_err, 0);
    rst_n = 1'b1;
    module_en = 1'b1;
    run(5);

    // Held left press: exactly one request, then busy.
    cnt_jl = 0; cnt_jr = 0;
    btn_left = 1'b1;
    run(300);
    check_eq("s1_jl_count", cnt_jl, 1);
    check_eq("s1_busy", busy, 1);
    btn_left = 1'b0;
    run(300);
    land();
    check_eq("s1_idle_after_land", busy, 0);
    run(10);

    // Right glitch shorter than the debounce window.
    cnt_jr = 0;
    btn_right = 1'b1;
    run(3 * TickDiv);
    btn_right = 1'b0;
    run(300);
    check_eq("s2_glitch_jr", cnt_jr, 0);

    // Right press while a left jump is in flight, then landed.
    btn_left = 1'b1;
    run(300);
    btn_left = 1'b0;
    run(300);
    btn_right = 1'b1;
    run(300);
    btn_right = 1'b0;
    run(300);
    cnt_jr = 0;
    land();
    run(10);
    check_eq("s3_buffered_jr", cnt_jr, BufEn ? 1 : 0);
    land();
    run(10);

    // No landed: watchdog expires, then a new press issues normally.
    btn_left = 1'b1;
    run(300);
    btn_left = 1'b0;
    run(4300);
    check_eq("s4_timeout_err", timeout_err, 1);
    check_eq("s4_busy_dropped", busy, 0);
    cnt_jl = 0;
    btn_left = 1'b1;
    run(300);
    check_eq("s4_reissue_jl", cnt_jl, 1);
    btn_left = 1'b0;
    run(300);
    land();
    run(10);

    // Both buttons together: left only.
    cnt_jl = 0; cnt_jr = 0;
    btn_left = 1'b1; btn_right = 1'b1;
    run(300);
    check_eq("s5_both_jl", cnt_jl, 1);
    check_eq("s5_both_jr", cnt_jr, 0);
    btn_left = 1'b0; btn_right = 1'b0;
    run(300);
    land();
    run(10);

    // Async reset mid-flight with a buffered press.
    btn_left = 1'b1;
    run(300);
    btn_right = 1'b1;
    run(300);
    check_eq("s6_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("s6_async_busy", busy, 0);
    check_eq("s6_async_err", timeout_err, 0);
    check_eq("s6_async_jl", jump_left, 0);
    btn_left = 1'b0; btn_right = 1'b0;
    run(5);
    rst_n = 1'b1;
    cnt_jl = 0; cnt_jr = 0;
    land();
    run(400);
    check_eq("s6_no_req_jl", cnt_jl, 0);
    check_eq("s6_no_req_jr", cnt_jr, 0);

    // Button held across enable rising must not fire.
    module_en = 1'b0;
    btn_left = 1'b1;
    run(300);
    module_en = 1'b1;
    cnt_jl = 0;
    run(300);
    check_eq("s7_held_no_jl", cnt_jl, 0);
    btn_left = 1'b0;
    run(300);
    btn_left = 1'b1;
    run(300);
    check_eq("s7_repress_jl", cnt_jl, 1);
    btn_left = 1'b0;
    run(300);
    land();
    run(10);

    // Random traffic.
    for (int s = 0; s < 40; s++) begin
      int len;
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      module_en = ($urandom_range(0, 7) != 0);
      len = int'($urandom_range(20, 600));
      for (int c = 0; c < len; c++) begin
        landed = ($urandom_range(0, 79) == 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
